// File: rtl/m_lsu.sv
// m_lsu: load/store unit between CPU requests and a word-wide data memory; byte/half stores use read-modify-write.
// Define LSU_TRACE_EN to print every data-memory write.
module m_lsu #(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_we, r_signed, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_data;
  logic        w_accept, w_fault;
  logic [4:0]  w_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld, w_wd;
  assign w_accept = req_valid & req_ready;
  assign w_fault  = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                    (req_size == 2'b10 & |req_addr[1:0]) | (req_addr >= 32'(4 * DM_WORDS));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !w_accept ? IDLE : w_fault ? RESP :
                        (req_we && req_size == 2'b10) ? WRITE : READ;
      READ:    w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_data   <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_signed <= req_signed;
        r_err    <= w_fault;
        r_size   <= req_size;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == READ) r_data <= dm_rd;
    end
  end
  // Little-endian lane pick from the word captured in READ
  assign w_sh   = {r_addr[1:0], 3'b000};
  assign w_byte = 8'(r_data >> w_sh);
  assign w_half = r_addr[1] ? r_data[31:16] : r_data[15:0];
  assign w_ld   = r_size == 2'b10 ? r_data :
                  r_size == 2'b01 ? {{16{r_signed & w_half[15]}}, w_half} :
                                    {{24{r_signed & w_byte[7]}}, w_byte};
  assign w_wd   = r_size == 2'b10 ? r_wdata :
                  r_size == 2'b01 ? (r_addr[1] ? {r_wdata[15:0], r_data[15:0]} : {r_data[31:16], r_wdata[15:0]}) :
                                    (r_data & ~(32'hFF << w_sh)) | ({24'h0, r_wdata[7:0]} << w_sh);
  always_comb begin
    req_ready = reset && r_state == IDLE;
    rsp_valid = r_state == RESP;
    rsp_err   = r_state == RESP && r_err;
    rsp_rdata = (r_state == RESP && !r_err && !r_we) ? w_ld : '0;
    dm_we     = r_state == WRITE;
    dm_addr   = (r_state == READ || r_state == WRITE) ? {r_addr[31:2], 2'b00} : '0;
    dm_wd     = r_state == WRITE ? w_wd : '0;
  end
`ifdef LSU_TRACE_EN
  logic [31:0] r_pc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_pc <= '0;
    else if (w_accept) r_pc <= req_pc;
  end
  always @(posedge clk) if (dm_we) $display("%d@%h: *%h <= %h", $time, r_pc, dm_addr, dm_wd);
`else
  logic w_unused_pc;
  assign w_unused_pc = ^req_pc;
`endif
endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: randomized and directed checks of m_lsu against a word-array reference model.
module tb_m_lsu;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
  logic        req_ready, rsp_valid, rsp_err, dm_we;
  logic [31:0] rsp_rdata, dm_addr, dm_wd, dm_rd;
  logic [31:0] mem [0:4095];
  logic [31:0] ref_mem [0:15];
  int n_chk = 0, n_pass = 0;

  m_lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;
  assign dm_rd = mem[dm_addr[13:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[13:2]] <= dm_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic scramble();
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_pc     = $urandom;
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] o_rd, output logic o_err, output int o_lat,
                        output logic [31:0] o_wd);
    logic        fault, er;
    logic [31:0] old, lane, mask, nw, e_rd, waddr, wdv, rd;
    int          sh, e_lat, nwe, lat;
    fault = sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || a >= 12288;
    old   = fault ? 32'h0 : ref_mem[a[5:2]];
    sh    = 8 * int'(a % 4);
    mask  = sz == 0 ? 32'hFF : sz == 1 ? 32'hFFFF : 32'hFFFF_FFFF;
    lane  = (old >> sh) & mask;
    e_lat = fault ? 1 : !we ? 2 : sz == 2 ? 2 : 3;
    e_rd  = 0;
    if (!fault && !we) begin
      e_rd = lane;
      if (sg && sz == 0 && lane >= 128)   e_rd = lane + 32'hFFFF_FF00;
      if (sg && sz == 1 && lane >= 32768) e_rd = lane + 32'hFFFF_0000;
    end
    nw = sz == 2 ? wd : old - (lane << sh) + ((wd & mask) << sh);
    check("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_pc = $urandom;
    @(posedge clk); #1;
    scramble();
    lat = 0; nwe = 0; waddr = 0; wdv = 0; rd = 0; er = 0;
    for (int k = 1; k <= 8; k++) begin
      if (dm_we) begin nwe++; waddr = dm_addr; wdv = dm_wd; end
      if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; break; end
      @(posedge clk); #1;
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("rsp_err", 32'(er), 32'(fault));
    check("rsp_rdata", rd, e_rd);
    check("dm_we_pulses", 32'(nwe), (!fault && we) ? 32'd1 : 32'd0);
    if (!fault && we) begin
      check("dm_addr", waddr, a & 32'hFFFF_FFFC);
      check("dm_wd", wdv, nw);
      ref_mem[a[5:2]] = nw;
    end
    @(posedge clk); #1;
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    o_rd = rd; o_err = er; o_lat = lat; o_wd = wdv;
  endtask

  initial begin
    logic [31:0] rd, wdv, a;
    logic        er;
    int          lat, nwe, nrsp, r;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wd", dm_wd, 32'd0);
    reset = 1'b1;
    #1 check("ready_after_rst", 32'(req_ready), 32'd1);
    for (int i = 0; i < 16; i++) do_req(1, 2, 0, 32'(4 * i), $urandom, rd, er, lat, wdv);
    // word store / load round trip
    do_req(1, 2, 0, 32'h10, 32'hDEADBEEF, rd, er, lat, wdv);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_wd", wdv, 32'hDEADBEEF);
    do_req(0, 2, 0, 32'h10, 32'h0, rd, er, lat, wdv);
    check("lw_data", rd, 32'hDEADBEEF);
    // byte store read-modify-write
    do_req(1, 2, 0, 32'h20, 32'h11223344, rd, er, lat, wdv);
    do_req(1, 0, 0, 32'h22, 32'h5A5A_55AA, rd, er, lat, wdv);
    check("sb_wd", wdv, 32'h11AA3344);
    check("sb_lat", 32'(lat), 32'd3);
    // load extension
    do_req(1, 2, 0, 32'h30, 32'h8000FF80, rd, er, lat, wdv);
    do_req(0, 0, 1, 32'h30, 32'h0, rd, er, lat, wdv);
    check("lb", rd, 32'hFFFFFF80);
    do_req(0, 0, 0, 32'h30, 32'h0, rd, er, lat, wdv);
    check("lbu", rd, 32'h00000080);
    do_req(0, 1, 1, 32'h32, 32'h0, rd, er, lat, wdv);
    check("lh", rd, 32'hFFFF8000);
    do_req(0, 1, 0, 32'h32, 32'h0, rd, er, lat, wdv);
    check("lhu", rd, 32'h00008000);
    // misaligned and out-of-range faults
    do_req(0, 2, 0, 32'h6, 32'h0, rd, er, lat, wdv);
    check("lw_mis_err", 32'(er), 32'd1);
    check("lw_mis_lat", 32'(lat), 32'd1);
    do_req(1, 1, 0, 32'h3, 32'h1234, rd, er, lat, wdv);
    check("sh_mis_err", 32'(er), 32'd1);
    do_req(1, 2, 0, 32'h3000, 32'hCAFEF00D, rd, er, lat, wdv);
    check("sw_oob_err", 32'(er), 32'd1);
    // reset during READ of a byte store aborts it
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h25; req_wdata = 32'h77;
    @(posedge clk); #1;
    scramble();
    reset = 1'b0;
    #1;
    check("abort_dm_we", 32'(dm_we), 32'd0);
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_dm_addr", dm_addr, 32'd0);
    nwe = 0; nrsp = 0;
    repeat (2) begin @(posedge clk); #1; nwe += int'(dm_we); nrsp += int'(rsp_valid); end
    reset = 1'b1;
    #1 check("ready_after_abort", 32'(req_ready), 32'd1);
    repeat (4) begin @(posedge clk); #1; nwe += int'(dm_we); nrsp += int'(rsp_valid); end
    check("abort_no_we", 32'(nwe), 32'd0);
    check("abort_no_rsp", 32'(nrsp), 32'd0);
    do_req(0, 2, 0, 32'h24, 32'h0, rd, er, lat, wdv);
    // random traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      a = r == 0 ? 32'h3000 + $urandom_range(0, 255) : r == 1 ? (32'h3000 | $urandom) : 32'($urandom_range(0, 63));
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd, er, lat, wdv);
    end
    for (int i = 0; i < 16; i++) do_req(0, 2, 0, 32'(4 * i), 32'h0, rd, er, lat, wdv);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/m_lsu.md
M_LSU -- requirements
Module: m_lsu

Interface
REQ-001 The block SHALL have parameter DM_WORDS, default 3072, giving the number of 32-bit words in the data memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the CPU presents a load/store request.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the request is accepted this cycle.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The block SHALL have port req_signed, input, 1 bit: sign-extend load data (lb/lh); otherwise zero-extend.
REQ-009 The block SHALL have ports req_addr, req_wdata and req_pc, input, 32 bits each: byte address, store data (right-aligned), and instruction PC.
REQ-010 The block SHALL have ports rsp_valid (1 bit), rsp_rdata (32 bits) and rsp_err (1 bit), all outputs: completion pulse, extended load data, and fault flag.
REQ-011 The block SHALL have ports dm_we (output, 1), dm_addr (output, 32), dm_wd (output, 32) and dm_rd (input, 32) connecting to data memory; dm_rd is the combinational read of word dm_addr[13:2], and a write with dm_we=1 commits at the rising edge.

Function
REQ-012 The FSM SHALL have states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE; acceptance SHALL be req_valid & req_ready.
REQ-013 On acceptance the block SHALL register req_we, req_size, req_signed, req_addr, req_wdata and req_pc; input changes after acceptance SHALL have no effect.
REQ-014 A request SHALL be faulting if req_size=11, size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or addr >= 4*DM_WORDS.
REQ-015 A faulting request SHALL go IDLE->RESP with no DM access (dm_we never 1), then give rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-016 A load SHALL go IDLE->READ->RESP; in READ, dm_addr={addr[31:2],2'b00}, and dm_rd is registered; rsp_valid occurs 2 cycles after acceptance.
REQ-017 A word store SHALL go IDLE->WRITE->RESP; in WRITE, dm_we=1 and dm_wd=wdata.
REQ-018 A byte or half store SHALL go IDLE->READ->WRITE->RESP, a read-modify-write; dm_wd SHALL equal the registered word with the selected lane(s) replaced by wdata[7:0] or wdata[15:0].
REQ-019 Lane selection SHALL be little-endian: byte k occupies bits [8k+7:8k] with k=addr[1:0]; a half uses bits [15:0] if addr[1]=0, otherwise [31:16].
REQ-020 Load data SHALL be the selected lane extended to 32 bits per req_signed; a word load SHALL be returned unmodified.
REQ-021 RESP SHALL last exactly 1 cycle with rsp_valid=1, then return to IDLE; a new request SHALL be acceptable in the following cycle.
REQ-022 dm_we SHALL be 1 only in WRITE; dm_addr SHALL hold the aligned address of the current request in READ and WRITE, and 0 otherwise.
REQ-023 A store SHALL return rsp_rdata=0 and rsp_err=0.

Reset
REQ-024 While reset=0, state SHALL be IDLE and rsp_valid, rsp_err, rsp_rdata, dm_we, dm_addr and dm_wd SHALL be 0; req_ready SHALL be 0.
REQ-025 Reset asserted mid-transaction SHALL abort it immediately: no dm_we pulse and no rsp_valid for the aborted request.
REQ-026 After reset deasserts, req_ready SHALL be 1 in the first cycle.

Configuration
REQ-027 With LSU_TRACE_EN defined, every cycle with dm_we=1 SHALL print "%d@%h: *%h <= %h" with $time, req_pc, dm_addr and dm_wd; without LSU_TRACE_EN, no display code SHALL be compiled and function SHALL be identical.

Verification
REQ-028 The bench SHALL cover: word store addr 0x10, data 0xDEADBEEF -> dm_we for one cycle at dm_addr 0x10; rsp_valid 2 cycles after acceptance; a later lw of 0x10 returns 0xDEADBEEF.
REQ-029 The bench SHALL cover: memory word 0x11223344; sb of 0xAA at addr+2 -> dm_wd 0x11AA3344; rsp_valid 3 cycles after acceptance.
REQ-030 The bench SHALL cover: memory word 0x8000FF80; lb at addr+0 -> 0xFFFFFF80; lbu -> 0x00000080; lh at addr+2 -> 0xFFFF8000; lhu -> 0x00008000.
REQ-031 The bench SHALL cover: lw at 0x6 and sh at 0x3 -> rsp_err=1 one cycle after acceptance; dm_we stays 0.
REQ-032 The bench SHALL cover: sw at 0x3000 with default DM_WORDS -> rsp_err=1; no write.
REQ-033 The bench SHALL cover: reset driven to 0 during READ of an sb -> no dm_we and no rsp_valid; req_ready=1 in the first cycle after release.
